// File: rtl/inv_cipher_round_ctrl.sv
// Round sequencer for the AES-128 decryption datapath: LOAD, NR-1 inverse rounds, FIN, result handshake.
// Optional AES_DEC_BLKCNT_EN adds a 16-bit completed-block counter output (blk_cnt).
module inv_cipher_round_ctrl #(
    parameter int NR      = 10,
    parameter int IMC_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        key_ready,
    output logic [3:0]  rk_addr,
    output logic        sel_load,
    output logic        sel_imc,
    output logic        state_we,
    output logic [3:0]  round_idx,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef AES_DEC_BLKCNT_EN
    output logic [15:0] blk_cnt,
`endif
    output logic        busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready and out_valid come from registers only, so neither depends on the opposite side.

    if (NR < 1 || NR > 15 || IMC_LAT < 0 || IMC_LAT > 7) begin : g_param_trap
        $error("inv_cipher_round_ctrl: NR must be 1..15 and IMC_LAT 0..7");
    end

    localparam logic [3:0] NR_L   = 4'(NR);
    localparam logic [3:0] NR_M1  = 4'(NR - 1);
    localparam logic [2:0] LAT_L  = 3'(IMC_LAT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RND  = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] rnd_cnt;
    logic [2:0] wait_cnt;
    logic       round_last;

    // The round result is valid once inv_mix_columns has had IMC_LAT cycles to settle.
    assign round_last = (state == S_RND) && (wait_cnt == LAT_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid && in_ready) state_next = S_LOAD;
            S_LOAD: state_next = (NR_M1 == 4'd0) ? S_FIN : S_RND;
            S_RND:  if (round_last && rnd_cnt == 4'd1) state_next = S_FIN;
            S_FIN:  state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rnd_cnt  <= 4'd0;
            wait_cnt <= 3'd0;
        end else begin
            case (state)
                S_LOAD: begin
                    rnd_cnt  <= NR_M1;
                    wait_cnt <= 3'd0;
                end
                S_RND: begin
                    if (round_last) begin
                        rnd_cnt  <= rnd_cnt - 4'd1;
                        wait_cnt <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: begin
                    wait_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Registered so key_ready has no combinational path to in_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_next == S_IDLE) && key_ready;
        end
    end

    always_comb begin
        rk_addr   = 4'd0;
        sel_load  = 1'b0;
        sel_imc   = 1'b0;
        state_we  = 1'b0;
        round_idx = 4'd0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_LOAD: begin
                rk_addr  = NR_L;
                sel_load = 1'b1;
                state_we = 1'b1;
            end
            S_RND: begin
                rk_addr   = rnd_cnt;
                sel_imc   = 1'b1;
                state_we  = round_last;
                round_idx = rnd_cnt;
            end
            S_FIN: begin
                state_we = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef AES_DEC_BLKCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_cnt <= 16'd0;
        end else if (state == S_DONE && out_ready) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

endmodule
